// File: rtl/rf_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths match the original 32x32 register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);

    typedef logic        [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic signed [RF_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-side bus of the register file: two read ports, one write port,
// the issue (mark) strobe and the busy flags.
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    // No handshake: WE and MarkWE are single-cycle strobes sampled on the
    // rising clock edge; reads and busy flags are combinational and always valid.
    logic        [ADDR_W-1:0] RR1;
    logic        [ADDR_W-1:0] RR2;
    logic signed [DATA_W-1:0] Out1;
    logic signed [DATA_W-1:0] Out2;
    logic                     Busy1;
    logic                     Busy2;
    logic        [ADDR_W-1:0] WR;
    logic signed [DATA_W-1:0] WD;
    logic                     WE;
    logic                     MarkWE;
    logic        [ADDR_W-1:0] MarkReg;
    logic                     AnyBusy;

    modport master (
        output RR1, RR2, WR, WD, WE, MarkWE, MarkReg,
        input  Out1, Out2, Busy1, Busy2, AnyBusy
    );

    modport slave (
        input  RR1, RR2, WR, WD, WE, MarkWE, MarkReg,
        output Out1, Out2, Busy1, Busy2, AnyBusy
    );

endinterface

// File: rtl/rf_scoreboard.sv
// One busy bit per register: set by an issue mark, cleared by the matching
// writeback, with the new issue winning when both hit the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mark_we_i,
    input  logic [ADDR_W-1:0] mark_reg_i,
    input  logic              clr_we_i,
    input  logic [ADDR_W-1:0] clr_reg_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              any_busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_we_i) begin
            busy_d[clr_reg_i] = 1'b0;
        end
        // Applied after the clear so a same-register issue supersedes the write.
        if (mark_we_i) begin
            busy_d[mark_reg_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1_o    = busy_q[rd1_addr_i];
    assign busy2_o    = busy_q[rd2_addr_i];
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file: clocked write, two combinational reads with
// optional same-cycle bypass, optional hardwired-zero r0, busy scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int DEPTH      = RF_DEPTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    reg_file_sb_if.slave  bus
);

    logic signed [DATA_W-1:0] regs_q [DEPTH];

    logic wr_en;
    logic fwd_en;
    logic hit1;
    logic hit2;
    logic sb_busy1;
    logic sb_busy2;

    // r0 is reset to 0 and never written, so reads of it need no forcing.
    assign wr_en  = bus.WE && !((ZERO_REG != 0) && (bus.WR == ADDR_W'(ZERO_ADDR)));
    // Forwarding is suppressed during reset so outputs reflect reset contents.
    assign fwd_en = (BYPASS != 0) && wr_en && !Rst;
    assign hit1   = fwd_en && (bus.WR == bus.RR1);
    assign hit2   = fwd_en && (bus.WR == bus.RR2);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else if (wr_en) begin
            regs_q[bus.WR] <= bus.WD;
        end
    end

    assign bus.Out1 = hit1 ? bus.WD : regs_q[bus.RR1];
    assign bus.Out2 = hit2 ? bus.WD : regs_q[bus.RR2];

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .mark_we_i  (bus.MarkWE),
        .mark_reg_i (bus.MarkReg),
        .clr_we_i   (bus.WE),
        .clr_reg_i  (bus.WR),
        .rd1_addr_i (bus.RR1),
        .rd2_addr_i (bus.RR2),
        .busy1_o    (sb_busy1),
        .busy2_o    (sb_busy2),
        .any_busy_o (bus.AnyBusy)
    );

    // A forwarded read carries the final value, so it is not reported busy.
    assign bus.Busy1 = sb_busy1 && !hit1;
    assign bus.Busy2 = sb_busy2 && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing
// instance driven with identical stimulus.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    logic Clk;
    logic Rst;

    int n_pass;
    int n_total;

    logic signed [DATA_W-1:0] exp_q[$];

    reg_file_sb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ib ();
    reg_file_sb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) in ();

    reg_file_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1), .INIT_INDEX(1))
        dut_b (.Clk(Clk), .Rst(Rst), .bus(ib));

    reg_file_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(0), .INIT_INDEX(1))
        dut_n (.Clk(Clk), .Rst(Rst), .bus(in));

    // Clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic set_rd(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        ib.RR1 = r1; in.RR1 = r1;
        ib.RR2 = r2; in.RR2 = r2;
    endtask

    task automatic set_wr(input logic we, input logic [ADDR_W-1:0] wr, input logic signed [DATA_W-1:0] wd);
        ib.WE = we; in.WE = we;
        ib.WR = wr; in.WR = wr;
        ib.WD = wd; in.WD = wd;
    endtask

    task automatic set_mark(input logic m, input logic [ADDR_W-1:0] r);
        ib.MarkWE = m; in.MarkWE = m;
        ib.MarkReg = r; in.MarkReg = r;
    endtask

    task automatic edge_then_settle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        set_rd(5'd7, 5'd31);
        set_wr(1'b0, '0, '0);
        set_mark(1'b0, '0);
        #1;
        n_total++; if (ib.Out1 !== 32'sd7) $display("FAIL rst_out1 got %0d exp 7", ib.Out1); else n_pass++;
        n_total++; if (ib.Out2 !== 32'sd31) $display("FAIL rst_out2 got %0d exp 31", ib.Out2); else n_pass++;
        n_total++; if ({ib.Busy1, ib.Busy2, ib.AnyBusy} !== 3'b000) $display("FAIL rst_busy got %b exp 000", {ib.Busy1, ib.Busy2, ib.AnyBusy}); else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        n_total++; if (in.Out1 !== 32'sd7) $display("FAIL rst_rel_out1 got %0d exp 7", in.Out1); else n_pass++;
    endtask

    task automatic test_bypass();
        @(negedge Clk);
        set_rd(5'd5, 5'd6);
        set_wr(1'b1, 5'd5, -32'sd2000);
        #1;
        n_total++; if (ib.Out1 !== -32'sd2000) $display("FAIL byp_pre got %0d exp -2000", ib.Out1); else n_pass++;
        n_total++; if (in.Out1 !== 32'sd5) $display("FAIL nobyp_pre got %0d exp 5", in.Out1); else n_pass++;
        n_total++; if (ib.Out2 !== 32'sd6) $display("FAIL byp_other got %0d exp 6", ib.Out2); else n_pass++;
        edge_then_settle();
        n_total++; if (ib.Out1 !== -32'sd2000) $display("FAIL byp_post got %0d exp -2000", ib.Out1); else n_pass++;
        n_total++; if (in.Out1 !== -32'sd2000) $display("FAIL nobyp_post got %0d exp -2000", in.Out1); else n_pass++;
        @(negedge Clk);
        set_wr(1'b0, '0, '0);
    endtask

    task automatic test_zero_reg();
        @(negedge Clk);
        set_rd(5'd0, 5'd0);
        set_wr(1'b1, 5'd0, 32'sd1300);
        #1;
        n_total++; if (ib.Out1 !== 32'sd0) $display("FAIL zero_pre got %0d exp 0", ib.Out1); else n_pass++;
        edge_then_settle();
        n_total++; if (ib.Out1 !== 32'sd0) $display("FAIL zero_post got %0d exp 0", ib.Out1); else n_pass++;
        n_total++; if (in.Out2 !== 32'sd0) $display("FAIL zero_post_n got %0d exp 0", in.Out2); else n_pass++;
        @(negedge Clk);
        set_wr(1'b0, '0, '0);
        set_mark(1'b1, 5'd0);
        edge_then_settle();
        n_total++; if (ib.AnyBusy !== 1'b0) $display("FAIL zero_mark_any got %b exp 0", ib.AnyBusy); else n_pass++;
        n_total++; if (ib.Busy1 !== 1'b0) $display("FAIL zero_mark_busy got %b exp 0", ib.Busy1); else n_pass++;
        @(negedge Clk);
        set_mark(1'b0, '0);
    endtask

    task automatic test_scoreboard();
        @(negedge Clk);
        set_rd(5'd3, 5'd2);
        set_mark(1'b1, 5'd3);
        #1;
        n_total++; if (ib.Busy1 !== 1'b0) $display("FAIL sb_premark got %b exp 0", ib.Busy1); else n_pass++;
        edge_then_settle();
        n_total++; if (ib.Busy1 !== 1'b1) $display("FAIL sb_mark_busy1 got %b exp 1", ib.Busy1); else n_pass++;
        n_total++; if (ib.AnyBusy !== 1'b1) $display("FAIL sb_mark_any got %b exp 1", ib.AnyBusy); else n_pass++;
        n_total++; if (ib.Busy2 !== 1'b0) $display("FAIL sb_other_busy2 got %b exp 0", ib.Busy2); else n_pass++;
        @(negedge Clk);
        set_mark(1'b0, '0);
        edge_then_settle();
        n_total++; if (ib.Busy1 !== 1'b1) $display("FAIL sb_hold got %b exp 1", ib.Busy1); else n_pass++;
        @(negedge Clk);
        set_wr(1'b1, 5'd3, -32'sd2);
        #1;
        n_total++; if (ib.Busy1 !== 1'b0) $display("FAIL sb_byp_busy got %b exp 0", ib.Busy1); else n_pass++;
        n_total++; if (in.Busy1 !== 1'b1) $display("FAIL sb_nobyp_busy got %b exp 1", in.Busy1); else n_pass++;
        n_total++; if (in.Out1 !== 32'sd3) $display("FAIL sb_nobyp_old got %0d exp 3", in.Out1); else n_pass++;
        edge_then_settle();
        n_total++; if (ib.Busy1 !== 1'b0) $display("FAIL sb_clr_busy got %b exp 0", ib.Busy1); else n_pass++;
        n_total++; if (in.Out1 !== -32'sd2) $display("FAIL sb_clr_out got %0d exp -2", in.Out1); else n_pass++;
        @(negedge Clk);
        set_wr(1'b0, '0, '0);
        #1;
        n_total++; if (ib.AnyBusy !== 1'b0) $display("FAIL sb_clr_any got %b exp 0", ib.AnyBusy); else n_pass++;
    endtask

    task automatic test_priority();
        @(negedge Clk);
        set_rd(5'd4, 5'd6);
        set_mark(1'b1, 5'd4);
        set_wr(1'b1, 5'd4, 32'sd9);
        edge_then_settle();
        @(negedge Clk);
        set_mark(1'b0, '0);
        set_wr(1'b0, '0, '0);
        #1;
        n_total++; if (in.Out1 !== 32'sd9) $display("FAIL prio_data got %0d exp 9", in.Out1); else n_pass++;
        n_total++; if (ib.Busy1 !== 1'b1) $display("FAIL prio_busy got %b exp 1", ib.Busy1); else n_pass++;
        set_mark(1'b1, 5'd6);
        set_wr(1'b1, 5'd4, 32'sd9);
        edge_then_settle();
        @(negedge Clk);
        set_mark(1'b0, '0);
        set_wr(1'b0, '0, '0);
        #1;
        n_total++; if (ib.Busy1 !== 1'b0) $display("FAIL prio_clr4 got %b exp 0", ib.Busy1); else n_pass++;
        n_total++; if (ib.Busy2 !== 1'b1) $display("FAIL prio_set6 got %b exp 1", ib.Busy2); else n_pass++;
        n_total++; if (in.AnyBusy !== 1'b1) $display("FAIL prio_any got %b exp 1", in.AnyBusy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic signed [DATA_W-1:0] v;
        logic signed [DATA_W-1:0] e;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            v = 32'sd1000 + k;
            set_rd(ADDR_W'(10 + k), 5'd2);
            set_wr(1'b1, ADDR_W'(10 + k), v);
            exp_q.push_back(v);
            #1;
            n_total++; if (ib.Out1 !== v) $display("FAIL b2b_byp%0d got %0d exp %0d", k, ib.Out1, v); else n_pass++;
            n_total++; if (in.Out1 !== 32'(10 + k)) $display("FAIL b2b_old%0d got %0d exp %0d", k, in.Out1, 10 + k); else n_pass++;
        end
        @(negedge Clk);
        set_wr(1'b1, 5'd31, -32'sd1);
        exp_q.push_back(-32'sd1);
        edge_then_settle();
        @(negedge Clk);
        set_wr(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            set_rd(5'd0, (k < 3) ? ADDR_W'(10 + k) : 5'd31);
            #1;
            e = exp_q.pop_front();
            n_total++; if (in.Out2 !== e) $display("FAIL b2b_rb%0d got %0d exp %0d", k, in.Out2, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge Clk);
        set_rd(5'd5, 5'd1);
        set_wr(1'b1, 5'd1, 32'sd1200);
        edge_then_settle();
        @(negedge Clk);
        set_wr(1'b1, 5'd1, 32'sd55);
        #1;
        n_total++; if (in.Out2 !== 32'sd1200) $display("FAIL mid_pre got %0d exp 1200", in.Out2); else n_pass++;
        n_total++; if (ib.AnyBusy !== 1'b1) $display("FAIL mid_pre_any got %b exp 1", ib.AnyBusy); else n_pass++;
        #1;
        Rst = 1'b1;
        #1;
        n_total++; if (ib.Out2 !== 32'sd1) $display("FAIL mid_rst_byp got %0d exp 1", ib.Out2); else n_pass++;
        n_total++; if (in.Out2 !== 32'sd1) $display("FAIL mid_rst_out2 got %0d exp 1", in.Out2); else n_pass++;
        n_total++; if (ib.AnyBusy !== 1'b0) $display("FAIL mid_rst_any got %b exp 0", ib.AnyBusy); else n_pass++;
        n_total++; if (ib.Out1 !== 32'sd5) $display("FAIL mid_rst_out1 got %0d exp 5", ib.Out1); else n_pass++;
        edge_then_settle();
        @(negedge Clk);
        set_wr(1'b0, '0, '0);
        Rst = 1'b0;
        #1;
        n_total++; if (ib.Out2 !== 32'sd1) $display("FAIL mid_after got %0d exp 1", ib.Out2); else n_pass++;
        n_total++; if ({ib.Busy1, ib.Busy2, in.AnyBusy} !== 3'b000) $display("FAIL mid_after_busy got %b exp 000", {ib.Busy1, ib.Busy2, in.AnyBusy}); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_priority();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-file 32x32 register file.
- Clocked write port, two asynchronous read ports, optional write-to-read bypass, optional hardwired-zero register 0.
- Per-register busy scoreboard, so the datapath can stall reads of registers with an outstanding multi-cycle write.
- Sits between the instruction-decode stage and the ALU / writeback mux.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width (derived, not overridden).
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes and busy marks.
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports.
- INIT_INDEX, 1, 1: reset loads register i with value i; 0: reset clears all registers to 0.

Ports:
- Clk  input  1  system clock, rising edge active.
- Rst  input  1  asynchronous, active-high reset.
- RR1  input  ADDR_W  read address, port 1.
- RR2  input  ADDR_W  read address, port 2.
- Out1  output  DATA_W  read data, port 1 (signed).
- Out2  output  DATA_W  read data, port 2 (signed).
- Busy1  output  1  register RR1 has an outstanding write.
- Busy2  output  1  register RR2 has an outstanding write.
- WR  input  ADDR_W  write address.
- WD  input  DATA_W  write data (signed).
- WE  input  1  write enable; write commits on the Clk rising edge.
- MarkWE  input  1  issue strobe; sets the busy bit of MarkReg.
- MarkReg  input  ADDR_W  destination register being issued.
- AnyBusy  output  1  OR of all busy bits.

Behaviour:
- Reset (Rst=1, asynchronous, immediate):
  - Registers load i (INIT_INDEX=1) or 0. With ZERO_REG=1, register 0 is always 0.
  - All busy bits clear.
  - Outputs follow combinationally from the reset state: Out1/Out2 = reset contents at RR1/RR2, Busy1/Busy2/AnyBusy = 0.
  - Reset asserted mid-write wins; the write is lost.
- Write:
  - On the Clk rising edge with WE=1, reg[WR] <= WD.
  - Ignored when ZERO_REG=1 and WR=0.
  - A write and its bypass are one cycle: no latency beyond the edge.
- Read:
  - Combinational from RR1/RR2 and storage, zero latency. Replaces the old sensitivity-list read.
  - With BYPASS=1, WE=1, WR==RRn and (WR!=0 or ZERO_REG=0): Outn = WD in the same cycle, before the edge.
  - With BYPASS=0: Outn shows the old value until after the edge.
  - Reading register 0 with ZERO_REG=1 returns 0 regardless of WE/WD.
- Scoreboard (one busy bit per register):
  - Set on the rising edge with MarkWE=1 for MarkReg.
  - Cleared on the rising edge with WE=1 for WR.
  - Same edge, same register, both MarkWE and WE: busy stays 1, since the new issue supersedes the write.
  - Same edge, different registers: both actions apply.
  - Register 0 with ZERO_REG=1 is never busy.
  - Busyn = busy[RRn], except that with BYPASS=1 and a same-cycle write to RRn, Busyn = 0. This matches the forwarded data.
  - Marking an already-busy register keeps it busy; no counting.
  - A write to a non-busy register is legal and leaves it clear.
- Width rules:
  - No arithmetic; data passes bit-exact.
  - Address bits above DEPTH-1 cannot occur (ADDR_W exact).

Decomposition:
- Shared package rf_pkg:
  - Default DATA_W and DEPTH constants.
  - Typedefs reg_addr_t and reg_data_t.
  - Constant ZERO_ADDR.
- Sub-module rf_scoreboard:
  - DEPTH busy flops with set/clear/priority logic and two read taps plus AnyBusy.
  - Instantiated once inside reg_file_sb.

Test Plan:
1. Reset with INIT_INDEX=1, no writes, RR1=7, RR2=31 -> Out1=7, Out2=31, Busy1=Busy2=AnyBusy=0.
2. WE=1, WR=5, WD=-2000, RR1=5, BYPASS=1 -> Out1=-2000 before the edge, still -2000 after it. Repeat with BYPASS=0 -> Out1=5 before the edge, -2000 after it.
3. ZERO_REG=1: WE=1, WR=0, WD=1300, RR1=0 -> Out1=0 before and after the edge; MarkWE on register 0 -> AnyBusy stays 0.
4. MarkWE, MarkReg=3 at edge n -> Busy1=1 for RR1=3 and AnyBusy=1. WE, WR=3, WD=-2 at edge n+2 -> Busy1=0, Out1=-2 after that edge.
5. At one edge: MarkWE, MarkReg=4 together with WE, WR=4, WD=9 -> reg4=9 and busy[4]=1. Next edge: MarkWE, MarkReg=6 with WE, WR=4 -> busy[4]=0, busy[6]=1.
6. Write 1200 to register 1, then assert Rst between clock edges while WE=1, WR=1, WD=55 -> Out2 for RR2=1 drops to 1 immediately, all busy bits 0, the write of 55 is not committed.
